// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// slave is the loader side, master the producer / memory side.
`timescale 1ns/1ps
interface instr_loader_if #(
  parameter int INSTR_BIT = 8
);
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 mem_we;
  logic [INSTR_BIT-1:0] mem_addr;
  logic [31:0]          mem_wdata;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Packs a byte stream into 32-bit instruction words and writes them to memory from
// address 0. After a clean load it pulses St and stays busy until the core reports done.
`timescale 1ns/1ps
module instr_loader #(
  parameter int INSTR_BIT = 8,
  parameter bit BYTE_LE   = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_en,
  input  logic               done,
  output logic               St,
  output logic               busy,
  output logic [INSTR_BIT:0] prog_len,
  output logic               err,
  instr_loader_if.slave      bus
);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, ERR} state_t;

  localparam logic [INSTR_BIT-1:0] ADDR_MAX = '1;
  localparam logic [INSTR_BIT-1:0] ADDR_ONE = 1;
  localparam logic [INSTR_BIT:0]   LEN_ONE  = 1;

  state_t               state;
  logic [1:0]           byte_cnt;
  logic [1:0]           lane;
  logic [INSTR_BIT-1:0] addr;
  logic [31:0]          shreg;
  logic [31:0]          word_nxt;
  logic                 load_q;
  logic                 load_rise;
  logic                 accept;
  logic                 word_done;

  assign load_rise = load_en & ~load_q;
  assign accept    = bus.in_valid & bus.in_ready;
  assign word_done = (byte_cnt == 2'd3);
  // Big-endian order fills lanes 3..0, which is the bitwise inverse of the count.
  assign lane      = BYTE_LE ? byte_cnt : ~byte_cnt;

  always_comb begin
    word_nxt = shreg;
    word_nxt[8*lane +: 8] = bus.in_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      addr          <= '0;
      shreg         <= '0;
      load_q        <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      St            <= 1'b0;
      busy          <= 1'b0;
      prog_len      <= '0;
      err           <= 1'b0;
    end else begin
      load_q     <= load_en;
      bus.mem_we <= 1'b0;
      St         <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (load_rise) begin
            state        <= LOAD;
            byte_cnt     <= '0;
            addr         <= '0;
            shreg        <= '0;
            err          <= 1'b0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        LOAD: begin
          // Abort has priority: a byte offered alongside the load_en drop is dropped.
          if (!load_en) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
          end else if (accept) begin
            shreg    <= word_nxt;
            byte_cnt <= byte_cnt + 2'd1;
            if (word_done) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= addr;
              bus.mem_wdata <= word_nxt;
              addr          <= addr + ADDR_ONE;
              if (bus.in_last) begin
                state        <= START;
                prog_len     <= {1'b0, addr} + LEN_ONE;
                bus.in_ready <= 1'b0;
              end else if (addr == ADDR_MAX) begin
                state        <= ERR;
                err          <= 1'b1;
                bus.in_ready <= 1'b0;
                busy         <= 1'b0;
              end
            end else if (bus.in_last) begin
              state        <= ERR;
              err          <= 1'b1;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
            end
          end
        end
        START: begin
          St    <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          // St is still high in the first RUN cycle; a done seen alongside it is ignored.
          if (done && !St) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: two loaders (little- and big-endian packing,
// 4-word memory) share one stimulus stream and are checked against a queue-based model.
`timescale 1ns/1ps
module tb_instr_loader;
  localparam int DEPTH = 4;

  typedef struct {
    int unsigned win;
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int unsigned win;
    logic [1:0]  addr;
    logic [31:0] dle;
    logic [31:0] dbe;
  } exp_t;

  logic       CLK, RST, load_en, done;
  logic       in_valid, in_last;
  logic [7:0] in_data;
  logic       st_l, st_b, busy_l, busy_b, err_l, err_b;
  logic [2:0] plen_l, plen_b;

  instr_loader_if #(.INSTR_BIT(2)) bl ();
  instr_loader_if #(.INSTR_BIT(2)) bb ();

  assign bl.in_valid = in_valid;
  assign bl.in_data  = in_data;
  assign bl.in_last  = in_last;
  assign bb.in_valid = in_valid;
  assign bb.in_data  = in_data;
  assign bb.in_last  = in_last;

  instr_loader #(.INSTR_BIT(2), .BYTE_LE(1'b1)) u_le (
    .CLK(CLK), .RST(RST), .load_en(load_en), .done(done), .St(st_l), .busy(busy_l),
    .prog_len(plen_l), .err(err_l), .bus(bl)
  );

  instr_loader #(.INSTR_BIT(2), .BYTE_LE(1'b0)) u_be (
    .CLK(CLK), .RST(RST), .load_en(load_en), .done(done), .St(st_b), .busy(busy_b),
    .prog_len(plen_b), .err(err_b), .bus(bb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  wr_t         wr_le[$], wr_be[$];
  int unsigned st_le[$], st_be[$];

  always @(negedge CLK) begin
    if (bl.mem_we) wr_le.push_back(wr_t'{win: cyc, addr: bl.mem_addr, data: bl.mem_wdata});
    if (bb.mem_we) wr_be.push_back(wr_t'{win: cyc, addr: bb.mem_addr, data: bb.mem_wdata});
    if (st_l) st_le.push_back(cyc);
    if (st_b) st_be.push_back(cyc);
  end

  int   n_chk = 0, n_fail = 0;
  int   exp_plen = 0;
  logic [7:0] sb[$];
  bit         sl[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero();
    chk("z_st",    {st_l, st_b}, 0);
    chk("z_busy",  {busy_l, busy_b}, 0);
    chk("z_err",   {err_l, err_b}, 0);
    chk("z_plen",  {plen_l, plen_b}, 0);
    chk("z_rdy",   {bl.in_ready, bb.in_ready}, 0);
    chk("z_we",    {bl.mem_we, bb.mem_we}, 0);
    chk("z_addr",  {bl.mem_addr, bb.mem_addr}, 0);
    chk("z_wdata", {bl.mem_wdata, bb.mem_wdata}, 0);
  endtask

  task automatic chk_writes(input exp_t ew[$]);
    chk("n_wr_le", wr_le.size(), ew.size());
    chk("n_wr_be", wr_be.size(), ew.size());
    for (int j = 0; j < ew.size() && j < wr_le.size(); j++) begin
      chk("wr_win_le",  wr_le[j].win,  ew[j].win);
      chk("wr_addr_le", wr_le[j].addr, ew[j].addr);
      chk("wr_data_le", wr_le[j].data, ew[j].dle);
    end
    for (int j = 0; j < ew.size() && j < wr_be.size(); j++) begin
      chk("wr_win_be",  wr_be[j].win,  ew[j].win);
      chk("wr_addr_be", wr_be[j].addr, ew[j].addr);
      chk("wr_data_be", wr_be[j].data, ew[j].dbe);
    end
  endtask

  // One load session over sb/sl. abort_k: byte index at which load_en drops (-1: never).
  // gmode: 0 no gaps, 1 alternate valid/idle, 2 random gaps.
  task automatic session(int abort_k, int gmode, bit do_done);
    int          n = sb.size();
    int          i = 0, nacc = 0, nw = 0;
    bit          in_load = 1'b1, ok = 1'b0, bad = 1'b0, tog = 1'b0, gap;
    int unsigned last_win = 0;
    exp_t        ew[$];
    logic [7:0]  b0, b1, b2, b3;

    in_valid = 1'b0; in_last = 1'b0; done = 1'b0;
    load_en = 1'b0; step();
    load_en = 1'b1; step();
    wr_le.delete(); wr_be.delete(); st_le.delete(); st_be.delete();
    chk("start_err",  {err_l, err_b}, 0);
    chk("start_rdy",  {bl.in_ready, bb.in_ready}, 2'b11);
    chk("start_busy", {busy_l, busy_b}, 2'b11);

    while (i < n) begin
      case (gmode)
        1:       gap = tog;
        2:       gap = ($urandom_range(0, 2) == 0);
        default: gap = 1'b0;
      endcase
      tog = ~tog;
      if (i == abort_k) begin
        load_en = 1'b0;
        gap = 1'b0;
      end
      in_valid = !gap;
      in_data  = gap ? 8'($urandom) : sb[i];
      in_last  = gap ? 1'($urandom) : sl[i];
      chk("rdy_le", bl.in_ready, in_load);
      chk("rdy_be", bb.in_ready, in_load);
      step();
      if (!in_load) begin
        i++;
      end else if (!load_en) begin
        in_load = 1'b0;
        i = n;
      end else if (!gap) begin
        nacc++;
        if (nacc % 4 == 0) begin
          b0 = sb[i-3]; b1 = sb[i-2]; b2 = sb[i-1]; b3 = sb[i];
          ew.push_back(exp_t'{win: cyc, addr: 2'(nw), dle: {b3, b2, b1, b0}, dbe: {b0, b1, b2, b3}});
          nw++;
          if (sl[i]) begin
            ok = 1'b1; in_load = 1'b0; last_win = cyc; exp_plen = nw;
          end else if (nw == DEPTH) begin
            bad = 1'b1; in_load = 1'b0;
          end
        end else if (sl[i]) begin
          bad = 1'b1; in_load = 1'b0;
        end
        i++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    if (ok) begin
      step();
      chk("st_le", st_l, 1);
      chk("st_be", st_b, 1);
      chk("err_ok", {err_l, err_b}, 0);
      chk("rdy_start", {bl.in_ready, bb.in_ready}, 0);
      chk("plen_le", plen_l, exp_plen);
      chk("plen_be", plen_b, exp_plen);
      chk_writes(ew);
      if (!do_done) return;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      done     = 1'($urandom);
      step();
      done = 1'b0;
      chk("st_once",  {st_l, st_b}, 0);
      chk("busy_run", {busy_l, busy_b}, 2'b11);
      chk("rdy_run",  {bl.in_ready, bb.in_ready}, 0);
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom);
        step();
        chk("busy_wait", {busy_l, busy_b}, 2'b11);
        chk("rdy_wait",  {bl.in_ready, bb.in_ready}, 0);
      end
      in_valid = 1'b0;
      done = 1'b1;
      step();
      done = 1'b0;
      chk("busy_done", {busy_l, busy_b}, 0);
      step();
      chk("no_restart", {busy_l, busy_b, bl.in_ready}, 0);
      chk("n_st", {16'(st_le.size()), 16'(st_be.size())}, {16'd1, 16'd1});
      if (st_le.size() > 0) chk("st_win", st_le[0], last_win + 1);
    end else begin
      step(); step();
      chk("err_end_le", err_l, bad);
      chk("err_end_be", err_b, bad);
      chk("busy_end", {busy_l, busy_b}, 0);
      chk("rdy_end",  {bl.in_ready, bb.in_ready}, 0);
      chk("n_st_none", st_le.size() + st_be.size(), 0);
      chk("plen_keep", {plen_l, plen_b}, {3'(exp_plen), 3'(exp_plen)});
    end
    chk_writes(ew);
  endtask

  task automatic fill(int n, int last_at);
    sb.delete(); sl.delete();
    for (int j = 0; j < n; j++) begin
      sb.push_back(8'($urandom));
      sl.push_back(j == last_at);
    end
  endtask

  task automatic fill_seq(int n, int last_at);
    sb.delete(); sl.delete();
    for (int j = 0; j < n; j++) begin
      sb.push_back(8'(8'h11 * (j + 1)));
      sl.push_back(j == last_at);
    end
  endtask

  initial begin
    int kind, nb, ak;
    RST = 1'b0; load_en = 1'b0; done = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) step();
    chk_zero();
    RST = 1'b1;
    step();

    fill_seq(8, 7);   session(-1, 0, 1);   // two words, 0x44332211 / 0x88776655
    fill_seq(6, 5);   session(-1, 0, 1);   // misaligned last
    fill_seq(20, -1); session(-1, 0, 1);   // overflow
    fill_seq(16, 15); session(-1, 0, 1);   // full depth legal
    fill_seq(5, -1);  session(3, 0, 1);    // abort after 3 bytes
    fill_seq(4, 3);   session(-1, 1, 1);   // gapped single word

    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 3);
      ak = -1;
      case (kind)
        0: begin nb = 4 * $urandom_range(1, DEPTH); fill(nb, nb - 1); end
        1: begin
          nb = $urandom_range(1, 15);
          if (nb % 4 == 0) nb++;
          fill(nb, nb - 1);
        end
        2: begin nb = $urandom_range(17, 22); fill(nb, -1); end
        default: begin
          nb = $urandom_range(2, 13);
          ak = $urandom_range(0, nb - 1);
          fill(nb, -1);
        end
      endcase
      session(ak, 2, 1);
    end

    // Asynchronous reset while running: outputs clear mid-cycle and St does not return.
    fill(8, 7);
    session(-1, 2, 0);
    #2 RST = 1'b0;
    #1 chk_zero();
    exp_plen = 0;
    #3 RST = 1'b1;
    load_en = 1'b0;
    repeat (4) begin
      step();
      chk("post_rst_st",   st_l | st_b, 0);
      chk("post_rst_busy", busy_l | busy_b, 0);
    end
    fill(12, 11);
    session(-1, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream stage of the processor.
- Receives a program as a byte stream over a valid/ready handshake and assembles each 4 bytes into a 32-bit instruction word.
- Writes each word into instruction memory at consecutive addresses starting at 0.
- After the last word is written, issues a one-cycle St pulse to start the processor, then stays busy until the processor reports done.

Parameters:
- INSTR_BIT, 8, instruction-address width; memory depth is 2**INSTR_BIT words.
- BYTE_LE, 1, byte order: 1 = first byte received goes to bits [7:0]; 0 = first byte goes to bits [31:24].

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- load_en  input  1  level; from IDLE, a rising sample starts a load session.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  program byte.
- in_last  input  1  qualifies the final byte of the program; valid only with in_valid.
- in_ready  output  1  loader accepts the byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  INSTR_BIT  write address.
- mem_wdata  output  32  assembled instruction.
- St  output  1  one-cycle start pulse to processor.
- done  input  1  processor halt indication (level or pulse).
- busy  output  1  high in every state except IDLE and ERR.
- prog_len  output  INSTR_BIT+1  number of words written in the last successful load.
- err  output  1  sticky error flag.

Behaviour:
- Byte acceptance: a byte is accepted when in_valid && in_ready at the CLK edge.
- Reset (RST low, asynchronous): state=IDLE, byte counter=0, word address=0, shift register=0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, St=0, busy=0, prog_len=0, err=0.
- IDLE:
  - in_ready=0.
  - load_en=1 -> LOAD. Byte counter, address and err are cleared.
- LOAD:
  - in_ready=1.
  - Each accepted byte is placed into the shift register lane given by the byte counter (0..3), honouring BYTE_LE; the counter then increments mod 4.
  - When the 4th byte is accepted, the next cycle has mem_we=1, mem_addr=current address, mem_wdata=assembled word. The address then increments. Write latency is 1 cycle after the 4th byte.
  - Back-to-back bytes at one per cycle are sustained; in_ready never drops in LOAD.
  - in_last on the 4th byte of a word: write the word, then go to START. prog_len = address+1.
  - in_last on a byte that is not the 4th: misaligned. Set err, issue no write for the partial word -> ERR.
  - Overflow: a word completes while the address = 2**INSTR_BIT-1 and in_last=0. Write that word, set err -> ERR. A program of exactly 2**INSTR_BIT words ending with in_last is legal; prog_len = 2**INSTR_BIT.
  - load_en deasserted mid-session -> abort to IDLE. No write occurs for a partial word; words already written stay in memory; prog_len is unchanged.
- START:
  - St=1 for exactly one cycle, in the cycle after the final mem_we.
  - Next state is RUN.
- RUN:
  - in_ready=0; bytes offered are not accepted.
  - done sampled high -> IDLE.
  - done arriving in the same cycle as St is ignored; the first done counted is the one sampled in RUN.
- ERR:
  - in_ready=0, busy=0, err=1.
  - Leaves only on a load_en rising edge. It then enters LOAD and clears err. Reset also clears it.
- Edge detection: load_en is edge-detected from a registered copy. Holding it high across sessions does not restart a load after RUN returns to IDLE.
- Outputs: all outputs are registered. mem_we, St and in_ready never glitch combinationally.
- Simultaneous events:
  - A byte accepted in the same cycle as a load_en drop: abort wins and the byte is discarded.
  - Reset during RUN: returns to IDLE with no St reissue.

Test Plan:
- Normal load: load_en=1; bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with in_last on 0x88, BYTE_LE=1 -> mem_we at addr 0 data 0x44332211, at addr 1 data 0x88776655; St pulses 1 cycle after the second write; prog_len=2; busy=1 until done, then 0.
- Misaligned last: 6 bytes, in_last on the 6th -> exactly one mem_we (addr 0); err=1; no St; state ERR; a new load_en edge clears err.
- Overflow: INSTR_BIT=2; 20 bytes, no in_last -> 4 writes (addr 0..3); err=1 after the 4th write; no St; further bytes see in_ready=0.
- Full-depth legal: INSTR_BIT=2; 16 bytes, in_last on the 16th -> 4 writes; prog_len=4; St=1; err=0.
- Abort and reset: load_en dropped after 3 bytes -> no write, IDLE, prog_len unchanged. Separately, RST low during RUN -> all outputs 0 immediately, without waiting for CLK.
- Handshake gaps: in_valid toggled 1/0 every cycle for 4 bytes with BYTE_LE=0 -> single write 0x11223344 (from bytes 0x11..0x44); St asserted; in_ready=0 in RUN while in_valid=1.
